sevenseg_scan_ctrl: RTL and testbench

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

---
 rtl/sevenseg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit seven-segment
//            display. Each digit is shown for DIV cycles, followed by GAP
//            cycles with all anodes off, so that segments do not ghost onto
//            the neighbouring digit. New display values are captured through
//            a ready/load handshake into a shadow register. They become
//            visible only at a frame boundary, so a frame never mixes old
//            and new digits.
// Ports    : clk    - single clock, rising edge
//            reset  - asynchronous, active-high
//            enable - 1 = scan, 0 = display dark
//            load   - capture request for value (accepted when ready=1)
//            value  - four BCD digits, [3:0] is the rightmost digit
//            ready  - 1 = a load in this cycle is accepted
//            digit  - BCD nibble for the external segment decoder
//            anode  - active-low digit select, bit i drives digit i
// Macro    : SEVENSEG_LZ_BLANK_EN - when defined, leading zeros are blanked.
//            Digit 0 is always lit, and slot timing is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_ctrl #(
    parameter int unsigned DIV = 16,   // cycles per SHOW slot, 2..65535
    parameter int unsigned GAP = 4     // dead-time cycles per slot, 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    output logic        ready,
    output logic [3:0]  digit,
    output logic [3:0]  anode
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] C_PRESC_LAST = 16'(DIV - 1);
    localparam logic [7:0]  C_GAP_LAST   = 8'(GAP - 1);
    localparam logic [3:0]  C_ANODE_OFF  = 4'b1111;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_presc;
    logic [7:0]  r_gapcnt;
    logic [15:0] r_shadow;
    logic [15:0] r_disp;
    logic        r_pending;
    logic        r_ready;
    logic [3:0]  r_digit;
    logic [3:0]  r_anode;

    logic        w_gap_last;
    logic        w_wrap;
    logic        w_commit;
    logic [15:0] w_disp_nx;
    logic [1:0]  w_slot_idx;
    logic [3:0]  w_slot_digit;
    logic [3:0]  w_slot_anode;

    // Last dead-time cycle after digit 3 while scanning: the frame boundary.
    assign w_gap_last = (r_state == ST_GAP) && (r_gapcnt == C_GAP_LAST);
    assign w_wrap     = w_gap_last && (r_idx == 2'd3) && enable;

    // Shadow moves to the display at a frame boundary, or at any time while
    // dark, because nothing is visible then.
    assign w_commit   = r_pending && ((r_state == ST_OFF) || w_wrap);
    assign w_disp_nx  = w_commit ? r_shadow : r_disp;

    // Index of the SHOW slot that the next edge may enter. From OFF this is
    // always slot 0. From GAP it is the following slot, and 3 wraps to 0.
    assign w_slot_idx = (r_state == ST_GAP) ? (r_idx + 2'd1) : 2'd0;

    // Registered outputs for the slot being entered. They are computed from
    // the post-commit display value, so a committing edge already shows the
    // new digit 0.
    always_comb begin
        w_slot_digit = w_disp_nx[3:0];
        w_slot_anode = ~(4'b0001 << w_slot_idx);
        case (w_slot_idx)
            2'd0:    w_slot_digit = w_disp_nx[3:0];
            2'd1:    w_slot_digit = w_disp_nx[7:4];
            2'd2:    w_slot_digit = w_disp_nx[11:8];
            default: w_slot_digit = w_disp_nx[15:12];
        endcase
`ifdef SEVENSEG_LZ_BLANK_EN
        // A slot is dark when its nibble and every nibble above it are zero.
        case (w_slot_idx)
            2'd1:    if (w_disp_nx[15:4]  == 12'h000) w_slot_anode = C_ANODE_OFF;
            2'd2:    if (w_disp_nx[15:8]  == 8'h00)   w_slot_anode = C_ANODE_OFF;
            2'd3:    if (w_disp_nx[15:12] == 4'h0)    w_slot_anode = C_ANODE_OFF;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_idx     <= 2'd0;
            r_presc   <= 16'd0;
            r_gapcnt  <= 8'd0;
            r_shadow  <= 16'h0000;
            r_disp    <= 16'h0000;
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
            r_digit   <= 4'h0;
            r_anode   <= C_ANODE_OFF;
        end else begin
            // Handshake. While a capture is pending, ready is 0, so a commit
            // and an accepted load never happen in the same cycle.
            if (w_commit) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end else if (load && r_ready) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
                r_ready   <= 1'b0;
            end

            // Scan sequencing. Dropping enable always restarts from slot 0.
            if (!enable) begin
                r_state  <= ST_OFF;
                r_idx    <= 2'd0;
                r_presc  <= 16'd0;
                r_gapcnt <= 8'd0;
                r_anode  <= C_ANODE_OFF;
                r_digit  <= 4'h0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state  <= ST_SHOW;
                        r_idx    <= 2'd0;
                        r_presc  <= 16'd0;
                        r_gapcnt <= 8'd0;
                        r_anode  <= w_slot_anode;
                        r_digit  <= w_slot_digit;
                    end
                    ST_SHOW: begin
                        if (r_presc == C_PRESC_LAST) begin
                            r_state  <= ST_GAP;
                            r_gapcnt <= 8'd0;
                            r_anode  <= C_ANODE_OFF;
                        end else begin
                            r_presc <= r_presc + 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_last) begin
                            r_state <= ST_SHOW;
                            r_idx   <= w_slot_idx;
                            r_presc <= 16'd0;
                            r_anode <= w_slot_anode;
                            r_digit <= w_slot_digit;
                        end else begin
                            r_gapcnt <= r_gapcnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_anode <= C_ANODE_OFF;
                        r_digit <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign ready = r_ready;
    assign digit = r_digit;
    assign anode = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan_ctrl
// Purpose  : Self-checking bench for sevenseg_scan_ctrl (DIV=4, GAP=2).
//            The reference model tracks the position inside a frame by
//            arithmetic on the number of cycles since scanning started.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        ready;
    logic [3:0]  digit;
    logic [3:0]  anode;

    int n_checks = 0;
    int n_pass   = 0;

    sevenseg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .value  (value),
        .ready  (ready),
        .digit  (digit),
        .anode  (anode)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        on;
        logic [31:0] t;
        logic [15:0] disp;
        logic [15:0] shadow;
        logic        pending;
        logic        rdy;
        logic [3:0]  dig;
        logic [3:0]  an;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.rdy = 1'b1;
        r.an  = 4'hF;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic en, logic ld, logic [15:0] v);
        model_t n;
        int pos;
        int slot;
        logic boundary;
        n = s;
        boundary = s.on && en && (((s.t + 32'd1) % FRAME) == 0);
        if (s.pending && (!s.on || boundary)) begin
            n.disp = s.shadow; n.pending = 1'b0; n.rdy = 1'b1;
        end else if (ld && s.rdy) begin
            n.shadow = v; n.pending = 1'b1; n.rdy = 1'b0;
        end
        if (!en) begin
            n.on = 1'b0; n.t = 32'd0; n.an = 4'hF; n.dig = 4'h0;
        end else begin
            if (!s.on) begin n.on = 1'b1; n.t = 32'd0; end
            else n.t = s.t + 32'd1;
            pos  = int'(n.t % FRAME);
            slot = pos / SLOT;
            if ((pos % SLOT) < DIV) begin
                n.dig = n.disp[slot*4 +: 4];
                n.an  = 4'(~(4'b0001 << slot));
`ifdef SEVENSEG_LZ_BLANK_EN
                if (slot != 0 && (n.disp >> (4*slot)) == 16'h0) n.an = 4'hF;
`endif
            end else begin
                n.an = 4'hF;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, enable, load, value);
    end

    function automatic int m_slot();
        return int'(m.t % FRAME) / SLOT;
    endfunction

    function automatic logic m_in_show();
        return m.on && (int'(m.t % FRAME) % SLOT) < DIV;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (anode !== 4'hF) $display("FAIL reset_anode got=%b exp=1111", anode); else n_pass++;
        n_checks++; if (digit !== 4'h0) $display("FAIL reset_digit got=%h exp=0", digit); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else n_pass++;
    endtask

    task automatic test_scan_sequence();
        logic [3:0] tbl [FRAME] = '{4'hE,4'hE,4'hE,4'hE,4'hF,4'hF,
                                    4'hD,4'hD,4'hD,4'hD,4'hF,4'hF,
                                    4'hB,4'hB,4'hB,4'hB,4'hF,4'hF,
                                    4'h7,4'h7,4'h7,4'h7,4'hF,4'hF};
        logic [3:0] exp;
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2*FRAME; k++) begin
            @(negedge clk);
            exp = tbl[k % FRAME];
`ifdef SEVENSEG_LZ_BLANK_EN
            if ((k % FRAME) / SLOT != 0) exp = 4'hF;
`endif
            n_checks++; if (anode !== exp) $display("FAIL scan_anode k=%0d got=%b exp=%b", k, anode, exp); else n_pass++;
            n_checks++; if (digit !== 4'h0) $display("FAIL scan_digit k=%0d got=%h exp=0", k, digit); else n_pass++;
        end
    endtask

    task automatic test_load_commit();
        int budget;
        logic [3:0] got [4];
        logic [3:0] want [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        budget = 0;
        while (!(m_in_show() && m_slot() == 1) && budget < 2*FRAME) begin @(negedge clk); budget++; end
        n_checks++; if (!(m_in_show() && m_slot() == 1)) $display("FAIL lc_wait_slot1 got=timeout exp=slot1"); else n_pass++;
        load = 1'b1; value = 16'h1234;
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) $display("FAIL lc_ready_low got=%b exp=0", ready); else n_pass++;
        value = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        n_checks++; if (digit !== 4'h0) $display("FAIL lc_digit_unchanged got=%h exp=0", digit); else n_pass++;
        budget = 0;
        while (ready !== 1'b1 && budget < 2*FRAME) begin
            @(negedge clk); budget++;
            n_checks++; if (anode !== m.an) $display("FAIL lc_anode got=%b exp=%b", anode, m.an); else n_pass++;
            if (ready !== 1'b1) begin
                n_checks++; if (digit !== 4'h0) $display("FAIL lc_digit_pre got=%h exp=0", digit); else n_pass++;
            end
        end
        n_checks++; if (ready !== 1'b1) $display("FAIL lc_commit got=timeout exp=ready1"); else n_pass++;
        n_checks++; if (anode !== 4'hE) $display("FAIL lc_commit_anode got=%b exp=1110", anode); else n_pass++;
        n_checks++; if (digit !== 4'h4) $display("FAIL lc_commit_digit got=%h exp=4", digit); else n_pass++;
        for (int i = 0; i < 4; i++) got[i] = 4'hF;
        for (int k = 0; k < FRAME - 1; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (anode == 4'(~(4'b0001 << i))) got[i] = digit;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got[i] !== want[i]) $display("FAIL lc_frame_digit%0d got=%h exp=%h", i, got[i], want[i]); else n_pass++;
        end
    endtask

    task automatic test_enable_off();
        int budget;
        int cnt [4];
        int want_hi;
        budget = 0;
        while (!(m_in_show() && m_slot() == 0) && budget < 2*FRAME) begin @(negedge clk); budget++; end
        n_checks++; if (ready !== 1'b1) $display("FAIL eo_ready_before got=%b exp=1", ready); else n_pass++;
        load = 1'b1; value = 16'h0042;
        @(negedge clk);
        load = 1'b0;
        budget = 0;
        while (!(m.on && !m_in_show() && m_slot() == 2) && budget < 2*FRAME) begin @(negedge clk); budget++; end
        n_checks++; if (!(m.on && !m_in_show() && m_slot() == 2)) $display("FAIL eo_wait_gap2 got=timeout exp=gap2"); else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (anode !== 4'hF) $display("FAIL eo_off_anode got=%b exp=1111", anode); else n_pass++;
        n_checks++; if (digit !== 4'h0) $display("FAIL eo_off_digit got=%h exp=0", digit); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL eo_off_ready got=%b exp=0", ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("FAIL eo_commit_ready got=%b exp=1", ready); else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_checks++; if (anode !== 4'hE) $display("FAIL eo_slot0_anode got=%b exp=1110", anode); else n_pass++;
        n_checks++; if (digit !== 4'h2) $display("FAIL eo_slot0_digit got=%h exp=2", digit); else n_pass++;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < FRAME - 1; k++) begin
            @(negedge clk);
            n_checks++; if (anode !== m.an || digit !== m.dig) $display("FAIL eo_frame got=%b/%h exp=%b/%h", anode, digit, m.an, m.dig); else n_pass++;
            for (int i = 0; i < 4; i++) if (anode == 4'(~(4'b0001 << i))) cnt[i]++;
        end
`ifdef SEVENSEG_LZ_BLANK_EN
        want_hi = 0;
`else
        want_hi = DIV;
`endif
        n_checks++; if (cnt[1] !== DIV) $display("FAIL eo_lit1 got=%0d exp=%0d", cnt[1], DIV); else n_pass++;
        n_checks++; if (cnt[2] !== want_hi) $display("FAIL eo_lit2 got=%0d exp=%0d", cnt[2], want_hi); else n_pass++;
        n_checks++; if (cnt[3] !== want_hi) $display("FAIL eo_lit3 got=%0d exp=%0d", cnt[3], want_hi); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 0;
        while (!(m_in_show() && m_slot() == 1) && budget < 2*FRAME) begin @(negedge clk); budget++; end
        load = 1'b1; value = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        budget = 0;
        while (!(m_in_show() && m_slot() == 2) && budget < 2*FRAME) begin @(negedge clk); budget++; end
        n_checks++; if (ready !== 1'b0) $display("FAIL rm_pending got=%b exp=0", ready); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (anode !== 4'hF) $display("FAIL rm_anode got=%b exp=1111", anode); else n_pass++;
        n_checks++; if (digit !== 4'h0) $display("FAIL rm_digit got=%h exp=0", digit); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL rm_ready got=%b exp=1", ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < FRAME + 2; k++) begin
            @(negedge clk);
            n_checks++; if (digit !== 4'h0) $display("FAIL rm_after_digit got=%h exp=0", digit); else n_pass++;
            n_checks++; if (ready !== 1'b1) $display("FAIL rm_after_ready got=%b exp=1", ready); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            n_checks++; if (anode !== m.an) $display("FAIL rand_anode k=%0d got=%b exp=%b", k, anode, m.an); else n_pass++;
            n_checks++; if (digit !== m.dig) $display("FAIL rand_digit k=%0d got=%h exp=%h", k, digit, m.dig); else n_pass++;
            n_checks++; if (ready !== m.rdy) $display("FAIL rand_ready k=%0d got=%b exp=%b", k, ready, m.rdy); else n_pass++;
            reset  = (($urandom % 400) == 0);
            enable = (($urandom % 80) != 0);
            load   = (($urandom % 6) == 0);
            value  = 16'($urandom);
        end
        reset = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_load_commit();
        test_enable_off();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
